// File: rtl/i2s_tx_serializer.sv
// I2S/MSB/LSB-justified transmit serializer: pops one PCM word per slot and shifts it out on sd_out.
// Latency: sd_out is registered, valid the clk after each sck_fall strobe; data_ready/underrun are same-cycle.
// Backpressure: data_ready pulses only at slot start (k=0); a missing word yields an underrun pulse and a zero slot.
module i2s_tx_serializer #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        standard,
    input  logic [1:0]        word_size,
    input  logic              frame_size,
    input  logic              stereo,
    input  logic              mute,
    input  logic              stop,
    input  logic              sck_fall,
    input  logic              ws_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              sd_out,
    output logic              underrun,
    output logic              busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nxt;
    logic              ws_prev;
    logic [4:0]        k, k_cur;
    logic [DATA_W-1:0] shreg, shreg_nxt, hold, hold_nxt, aligned;
    logic [1:0]        lat_w, new_w, eff_w;     // 0=16, 1=24, 2=32 bits
    logic [4:0]        lat_d, new_d, eff_d;
    logic              lat_stereo, lat_mute, eff_stereo, eff_mute;
    logic              ws_edge, ws_fall;
    logic              active, latch, exit_run, fetch;

    assign ws_edge = ws_in != ws_prev;
    assign ws_fall = ws_prev & ~ws_in;
    assign k_cur   = ws_edge ? 5'd0 : ((k == 5'd31) ? 5'd31 : k + 5'd1);
    assign busy    = (state == RUN);

    // Effective word width is clipped to the slot, so a 16-bit slot always sends 16 bits.
    always_comb begin
        new_w = 2'd2;
        new_d = 5'd1;
        if (!frame_size) begin
            new_w = 2'd0;
        end else begin
            case (word_size)
                2'b00:   new_w = 2'd0;
                2'b01:   new_w = 2'd1;
                default: new_w = 2'd2;
            endcase
        end
        case (standard)
            2'b01: new_d = 5'd0;
            2'b10: begin
                if (!frame_size) new_d = 5'd0;
                else if (new_w == 2'd0) new_d = 5'd16;
                else if (new_w == 2'd1) new_d = 5'd8;
                else new_d = 5'd0;
            end
            default: new_d = 5'd1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        active    = 1'b0;
        latch     = 1'b0;
        exit_run  = 1'b0;
        case (state)
            IDLE: begin
                if (sck_fall && ws_fall && !stop) begin
                    state_nxt = RUN;
                    active    = 1'b1;
                    latch     = 1'b1;
                end
            end
            RUN: begin
                if (sck_fall) begin
                    if (!ws_in && stop) begin
                        state_nxt = IDLE;
                        exit_run  = 1'b1;
                    end else begin
                        active = 1'b1;
                        latch  = ws_fall;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // On the latching strobe the fresh config must already steer the fetch and the load.
    always_comb begin
        eff_w      = latch ? new_w  : lat_w;
        eff_d      = latch ? new_d  : lat_d;
        eff_stereo = latch ? stereo : lat_stereo;
        eff_mute   = latch ? mute   : lat_mute;
        fetch      = active && (k_cur == 5'd0) && (!ws_in || eff_stereo);
        data_ready = rst_n & fetch & data_valid;
        underrun   = rst_n & fetch & ~data_valid;
        hold_nxt   = hold;
        if (fetch) hold_nxt = data_valid ? data_in : '0;
        case (eff_w)
            2'd0:    aligned = {hold_nxt[15:0], 16'h0000};
            2'd1:    aligned = {hold_nxt[23:0], 8'h00};
            default: aligned = hold_nxt;
        endcase
        shreg_nxt = (k_cur == eff_d) ? aligned : {shreg[DATA_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ws_prev    <= 1'b0;
            k          <= 5'd0;
            shreg      <= '0;
            hold       <= '0;
            sd_out     <= 1'b0;
            lat_w      <= 2'd0;
            lat_d      <= 5'd0;
            lat_stereo <= 1'b0;
            lat_mute   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (sck_fall) begin
                ws_prev <= ws_in;
                k       <= k_cur;
                if (latch) begin
                    lat_w      <= new_w;
                    lat_d      <= new_d;
                    lat_stereo <= stereo;
                    lat_mute   <= mute;
                end
                if (active) begin
                    hold   <= hold_nxt;
                    shreg  <= shreg_nxt;
                    sd_out <= shreg_nxt[DATA_W-1] & ~eff_mute;
                end else begin
                    sd_out <= 1'b0;
                    if (exit_run) shreg <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: driver queues hand-computed per-strobe expectations, monitor checks them.
module tb_i2s_tx_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  standard = 2'b01;
    logic [1:0]  word_size = 2'b01;
    logic        frame_size = 1'b1;
    logic        stereo = 1'b1;
    logic        mute = 1'b0;
    logic        stop = 1'b0;
    logic        sck_fall = 1'b0;
    logic        ws_in = 1'b0;
    logic [31:0] data_in = 32'h0;
    logic        data_valid = 1'b0;
    logic        data_ready, sd_out, underrun, busy;

    i2s_tx_serializer #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .standard(standard), .word_size(word_size),
        .frame_size(frame_size), .stereo(stereo), .mute(mute), .stop(stop),
        .sck_fall(sck_fall), .ws_in(ws_in), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .sd_out(sd_out), .underrun(underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic sd;
        logic rdy;
        logic und;
        logic bsy;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic pend = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: strobe cycle checks the pop/underrun strobes, the following sample checks sd_out and busy.
    always @(negedge clk) begin
        if (pend) begin
            chk("sd_out", {31'd0, sd_out}, {31'd0, cur.sd});
            chk("busy", {31'd0, busy}, {31'd0, cur.bsy});
            pend = 1'b0;
        end
        if (rst_n && sck_fall) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL strobe_without_expectation at %0t", $time);
            end else begin
                cur = exp_q.pop_front();
                chk("data_ready", {31'd0, data_ready}, {31'd0, cur.rdy});
                chk("underrun", {31'd0, underrun}, {31'd0, cur.und});
                pend = 1'b1;
            end
        end else begin
            chk("quiet_strobes", {30'd0, data_ready, underrun}, 32'd0);
        end
    end

    task automatic strobe(input logic ws, input logic dv, input logic [31:0] din, input exp_t e);
        @(posedge clk);
        #1;
        ws_in      = ws;
        data_valid = dv;
        data_in    = din;
        exp_q.push_back(e);
        sck_fall   = 1'b1;
        @(posedge clk);
        #1;
        sck_fall = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // pat holds the expected SD bit for strobe k at bit (n-1-k).
    task automatic slot(input logic ws, input int n, input logic dv, input logic [31:0] din,
                        input logic [31:0] pat, input logic rdy0, input logic und0,
                        input logic bsy, input int stop_k);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            if (k == stop_k) stop = 1'b1;
            e.sd  = pat[n-1-k];
            e.rdy = (k == 0) ? rdy0 : 1'b0;
            e.und = (k == 0) ? und0 : 1'b0;
            e.bsy = bsy;
            strobe(ws, dv, din, e);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sd_out", {31'd0, sd_out}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_data_ready", {31'd0, data_ready}, 32'd0);
        chk("reset_underrun", {31'd0, underrun}, 32'd0);
        rst_n = 1'b1;

        // Idle with ws high: no edge into left, nothing happens.
        slot(1'b1, 4, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, -1);

        // MSB-justified, 24-bit in 32-bit slots, stereo.
        standard = 2'b01; word_size = 2'b01; frame_size = 1'b1; stereo = 1'b1;
        slot(1'b0, 32, 1'b1, 32'h00ABCDEF, 32'hABCDEF00, 1'b1, 1'b0, 1'b1, -1);
        slot(1'b1, 32, 1'b1, 32'h00123456, 32'h12345600, 1'b1, 1'b0, 1'b1, -1);

        // I2S 32-bit: one-bit delay, LSB spills into next slot's k=0.
        standard = 2'b00; word_size = 2'b10;
        slot(1'b0, 32, 1'b1, 32'h80000001, 32'h40000000, 1'b1, 1'b0, 1'b1, -1);
        slot(1'b1, 32, 1'b1, 32'h00000003, 32'h80000001, 1'b1, 1'b0, 1'b1, -1);

        // LSB-justified 16-bit in 32-bit slot; k=0 carries the I2S spill bit.
        standard = 2'b10; word_size = 2'b00;
        slot(1'b0, 32, 1'b1, 32'h0000F00F, 32'h8000F00F, 1'b1, 1'b0, 1'b1, -1);
        slot(1'b1, 32, 1'b1, 32'h00001234, 32'h00001234, 1'b1, 1'b0, 1'b1, -1);

        // 16-bit slots with a 32-bit word: upper bits trimmed.
        standard = 2'b01; word_size = 2'b10; frame_size = 1'b0;
        slot(1'b0, 16, 1'b1, 32'h0001ABCD, 32'h0000ABCD, 1'b1, 1'b0, 1'b1, -1);
        slot(1'b1, 16, 1'b1, 32'h00005555, 32'h00005555, 1'b1, 1'b0, 1'b1, -1);

        // Mono: one pop per frame, right slot repeats left word.
        frame_size = 1'b1; stereo = 1'b0;
        slot(1'b0, 32, 1'b1, 32'hF0F0F0F0, 32'hF0F0F0F0, 1'b1, 1'b0, 1'b1, -1);
        slot(1'b1, 32, 1'b1, 32'h11111111, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b1, -1);

        // Mono muted: SD low, pops continue.
        mute = 1'b1;
        slot(1'b0, 32, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b1, -1);
        slot(1'b1, 32, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, -1);

        // Underrun at left slot start, then a normal right word.
        mute = 1'b0; stereo = 1'b1;
        slot(1'b0, 32, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b1, 1'b1, -1);
        slot(1'b1, 32, 1'b1, 32'hC0000003, 32'hC0000003, 1'b1, 1'b0, 1'b1, -1);

        // Stop during right slot: frame completes, then IDLE.
        slot(1'b0, 32, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1, -1);
        slot(1'b1, 32, 1'b1, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b1, 10);
        slot(1'b0, 32, 1'b1, 32'h77777777, 32'h00000000, 1'b0, 1'b0, 1'b0, -1);
        slot(1'b1, 32, 1'b1, 32'h77777777, 32'h00000000, 1'b0, 1'b0, 1'b0, -1);
        // Falling edge with stop still high: stays IDLE.
        slot(1'b0, 32, 1'b1, 32'h77777777, 32'h00000000, 1'b0, 1'b0, 1'b0, -1);
        stop = 1'b0;
        slot(1'b1, 32, 1'b1, 32'h77777777, 32'h00000000, 1'b0, 1'b0, 1'b0, -1);
        // Restart pops at the next falling edge.
        slot(1'b0, 32, 1'b1, 32'h87654321, 32'h87654321, 1'b1, 1'b0, 1'b1, -1);
        slot(1'b1, 32, 1'b1, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b1, -1);

        // Reset mid-frame, then no restart without a real falling edge.
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            logic [31:0] pat;
            pat   = 32'hFFFF0000;
            e.sd  = pat[31-k];
            e.rdy = (k == 0);
            e.und = 1'b0;
            e.bsy = 1'b1;
            strobe(1'b0, 1'b1, 32'hFFFF0000, e);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midframe_reset_sd_out", {31'd0, sd_out}, 32'd0);
        chk("midframe_reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        slot(1'b0, 4, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, -1);

        repeat (8) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
